tl_fragmenter_param: RTL and testbench

- Parametrised TileLink-UL fragmenter; successor to the fixed single-configuration fragmenter inside the control-bus interconnect coupler.
- Splits Get/PutFull/PutPartial requests larger than one beat into single-beat fragments on the outbound A channel.
- Tags each fragment's source with the original source, size and remaining-fragment count, so D responses are reassembled without per-source storage.
- Sits between a crossbar client port and a narrow single-beat slave (control registers, CLINT, PLIC-class devices).

---
 rtl/tl_fragmenter_param.sv | 89 ++++++++
 tb/tb_tl_fragmenter_param.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tl_fragmenter_param.sv
// tl_fragmenter_param: splits multi-beat TileLink-UL requests into single-beat fragments and reassembles D responses via source tagging.
module tl_fragmenter_param #(
   parameter int ADDR_W = 31,
   parameter int SRC_W = 8,
   parameter int SIZE_W = 3,
   parameter int BEAT_BYTES = 8,
   parameter int MAX_SIZE_LOG2 = 6,
   localparam int L = $clog2(BEAT_BYTES),
   localparam int DATA_W = 8 * BEAT_BYTES,
   localparam int FRAG_W = (MAX_SIZE_LOG2 - L > 1) ? MAX_SIZE_LOG2 - L : 1,
   localparam int OSRC_W = SRC_W + SIZE_W + FRAG_W
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_a_valid,
   output logic                  in_a_ready,
   input  logic [2:0]            in_a_opcode,
   input  logic [2:0]            in_a_param,
   input  logic [SIZE_W-1:0]     in_a_size,
   input  logic [SRC_W-1:0]      in_a_source,
   input  logic [ADDR_W-1:0]     in_a_address,
   input  logic [BEAT_BYTES-1:0] in_a_mask,
   input  logic [DATA_W-1:0]     in_a_data,
   input  logic                  in_a_corrupt,
   output logic                  in_d_valid,
   input  logic                  in_d_ready,
   output logic [2:0]            in_d_opcode,
   output logic [SIZE_W-1:0]     in_d_size,
   output logic [SRC_W-1:0]      in_d_source,
   output logic [DATA_W-1:0]     in_d_data,
   output logic                  in_d_corrupt,
   output logic                  out_a_valid,
   input  logic                  out_a_ready,
   output logic [2:0]            out_a_opcode,
   output logic [2:0]            out_a_param,
   output logic [SIZE_W-1:0]     out_a_size,
   output logic [OSRC_W-1:0]     out_a_source,
   output logic [ADDR_W-1:0]     out_a_address,
   output logic [BEAT_BYTES-1:0] out_a_mask,
   output logic [DATA_W-1:0]     out_a_data,
   output logic                  out_a_corrupt,
   input  logic                  out_d_valid,
   output logic                  out_d_ready,
   input  logic [2:0]            out_d_opcode,
   input  logic [SIZE_W-1:0]     out_d_size,
   input  logic [OSRC_W-1:0]     out_d_source,
   input  logic [DATA_W-1:0]     out_d_data,
   input  logic                  out_d_corrupt
);
   logic [FRAG_W-1:0] cnt, nm1, rem, drem;
   logic [FRAG_W:0] n;
   logic big, is_get, a_fire, suppress;
   logic [SRC_W-1:0] dsrc;
   logic [SIZE_W-1:0] lgsz;
   logic unused_ok;
   always_comb begin
      big = in_a_size > SIZE_W'(L);
      n = big ? (FRAG_W+1)'(1) << (in_a_size - SIZE_W'(L)) : (FRAG_W+1)'(1);
      nm1 = FRAG_W'(n - 1'b1);
      rem = nm1 - cnt;
   end
   assign is_get = in_a_opcode == 3'd4;
   assign out_a_valid = reset && in_a_valid;
   // A Get burst holds its inbound beat until the last fragment leaves
   assign in_a_ready = reset && out_a_ready && (!is_get || rem == '0);
   assign a_fire = out_a_valid && out_a_ready;
   assign out_a_opcode = in_a_opcode;
   assign out_a_param = in_a_param;
   assign out_a_data = in_a_data;
   assign out_a_corrupt = in_a_corrupt;
   assign out_a_size = big ? SIZE_W'(L) : in_a_size;
   assign out_a_address = in_a_address + (ADDR_W'(cnt) << L);
   assign out_a_source = {in_a_source, in_a_size, rem};
   assign out_a_mask = (is_get && big) ? '1 : in_a_mask;
   always_ff @(posedge clock)
      if (!reset) cnt <= '0;
      else if (a_fire) cnt <= (rem == '0) ? '0 : cnt + 1'b1;
   assign {dsrc, lgsz, drem} = out_d_source;
   // Only the final AccessAck of a fragmented Put reaches the master
   assign suppress = out_d_opcode == 3'd0 && drem != '0;
   assign in_d_valid = reset && out_d_valid && !suppress;
   assign out_d_ready = reset && (in_d_ready || suppress);
   assign in_d_opcode = out_d_opcode;
   assign in_d_size = lgsz;
   assign in_d_source = dsrc;
   assign in_d_data = out_d_data;
   assign in_d_corrupt = out_d_corrupt;
   assign unused_ok = ^out_d_size;
endmodule

// File: tb/tb_tl_fragmenter_param.sv
// tb_tl_fragmenter_param: scoreboard bench for the parametrised TileLink-UL fragmenter.
module tb_tl_fragmenter_param;
   logic clock = 0, reset = 0;
   logic in_a_valid = 0, in_a_ready, in_a_corrupt = 0;
   logic [2:0] in_a_opcode = 0, in_a_param = 0;
   logic [2:0] in_a_size = 0;
   logic [7:0] in_a_source = 0, in_a_mask = 0;
   logic [30:0] in_a_address = 0;
   logic [63:0] in_a_data = 0;
   logic in_d_valid, in_d_ready = 0, in_d_corrupt;
   logic [2:0] in_d_opcode, in_d_size;
   logic [7:0] in_d_source;
   logic [63:0] in_d_data;
   logic out_a_valid, out_a_ready = 0, out_a_corrupt;
   logic [2:0] out_a_opcode, out_a_param, out_a_size;
   logic [13:0] out_a_source;
   logic [30:0] out_a_address;
   logic [7:0] out_a_mask;
   logic [63:0] out_a_data;
   logic out_d_valid = 0, out_d_ready, out_d_corrupt = 0;
   logic [2:0] out_d_opcode = 0, out_d_size = 0;
   logic [13:0] out_d_source = 0;
   logic [63:0] out_d_data = 0;
   int checks = 0, failures = 0;
   typedef struct {
      logic [30:0] addr;
      logic [13:0] src;
      logic [2:0] size;
      logic [7:0] mask;
      logic rdy;
   } a_t;
   typedef struct {
      logic [2:0] op;
      logic [2:0] size;
      logic [7:0] src;
      logic [63:0] data;
   } d_t;
   a_t exp_a[$];
   d_t exp_d[$];

   tl_fragmenter_param dut (
      .clock(clock), .reset(reset),
      .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_opcode(in_a_opcode),
      .in_a_param(in_a_param), .in_a_size(in_a_size), .in_a_source(in_a_source),
      .in_a_address(in_a_address), .in_a_mask(in_a_mask), .in_a_data(in_a_data),
      .in_a_corrupt(in_a_corrupt),
      .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_opcode(in_d_opcode),
      .in_d_size(in_d_size), .in_d_source(in_d_source), .in_d_data(in_d_data),
      .in_d_corrupt(in_d_corrupt),
      .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
      .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
      .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
      .out_a_corrupt(out_a_corrupt),
      .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
      .out_d_size(out_d_size), .out_d_source(out_d_source), .out_d_data(out_d_data),
      .out_d_corrupt(out_d_corrupt)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clock) begin
      if (reset && out_a_valid && out_a_ready) begin
         if (exp_a.size() == 0) check("a_extra", 1, 0);
         else begin
            a_t e;
            e = exp_a.pop_front();
            check("a_addr", out_a_address, e.addr);
            check("a_src", out_a_source, e.src);
            check("a_size", out_a_size, e.size);
            check("a_mask", out_a_mask, e.mask);
            check("a_inrdy", in_a_ready, e.rdy);
         end
      end
      if (reset && out_a_valid && !out_a_ready) check("a_inrdy_bp", in_a_ready, 0);
   end

   always @(negedge clock) begin
      if (in_d_valid && in_d_ready) begin
         if (exp_d.size() == 0) check("d_extra", 1, 0);
         else begin
            d_t e;
            e = exp_d.pop_front();
            check("d_op", in_d_opcode, e.op);
            check("d_size", in_d_size, e.size);
            check("d_src", in_d_source, e.src);
            check("d_data", in_d_data, e.data);
         end
      end
   end

   task automatic send_a(input bit tog);
      bit done = 0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clock);
         if (in_a_ready) done = 1;
         @(posedge clock);
         #1;
         if (tog && !done) out_a_ready = !out_a_ready;
      end
      if (!done) check("a_timeout", 0, 1);
      in_a_valid = 0;
   endtask

   task automatic get6(input bit push);
      in_a_opcode = 3'd4; in_a_size = 3'd6; in_a_source = 8'h2A;
      in_a_address = 31'h1000; in_a_mask = 8'h0F; in_a_valid = 1;
      if (push)
         for (int i = 0; i < 8; i++)
            exp_a.push_back('{31'h1000 + 31'(8 * i), {8'h2A, 3'd6, 3'(7 - i)}, 3'd3, 8'hFF, i == 7});
   endtask

   task automatic send_d(input logic [2:0] op, input logic [13:0] src, input logic [63:0] data, input bit vis);
      out_d_opcode = op; out_d_source = src; out_d_data = data; out_d_size = 3'd3; out_d_valid = 1;
      if (vis) exp_d.push_back('{op, src[5:3], src[13:6], data});
      @(negedge clock);
      check("d_valid", in_d_valid, vis);
      check("d_ready", out_d_ready, vis ? in_d_ready : 1'b1);
      @(posedge clock);
      #1;
      out_d_valid = 0;
   endtask

   initial begin
      in_a_valid = 1; out_a_ready = 1; out_d_valid = 1; in_d_ready = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("rst_oav", out_a_valid, 0);
         check("rst_iar", in_a_ready, 0);
         check("rst_idv", in_d_valid, 0);
         check("rst_odr", out_d_ready, 0);
      end
      @(posedge clock);
      #1;
      in_a_valid = 0; out_d_valid = 0; in_d_ready = 0; reset = 1;
      @(posedge clock);
      #1;
      get6(1);
      send_a(0);
      get6(1);
      send_a(1);
      out_a_ready = 1;
      for (int b = 0; b < 4; b++) begin
         in_a_opcode = 3'd0; in_a_size = 3'd5; in_a_source = 8'h11;
         in_a_address = 31'h2000; in_a_mask = 8'(8'h81 << b); in_a_data = 64'(b); in_a_valid = 1;
         exp_a.push_back('{31'h2000 + 31'(8 * b), {8'h11, 3'd5, 3'(3 - b)}, 3'd3, 8'(8'h81 << b), 1'b1});
         send_a(0);
      end
      in_d_ready = 0;
      for (int r = 3; r > 0; r--) send_d(3'd0, {8'h11, 3'd5, 3'(r)}, 64'h0, 0);
      in_d_ready = 1;
      send_d(3'd0, {8'h11, 3'd5, 3'd0}, 64'h0, 1);
      send_d(3'd1, {8'h05, 3'd6, 3'd2}, 64'hDEADBEEF, 1);
      get6(1);
      repeat (3) @(posedge clock);
      #1;
      reset = 0; in_a_valid = 0;
      exp_a.delete();
      @(posedge clock);
      #1;
      reset = 1;
      for (int j = 0; j < 2; j++) begin
         in_a_opcode = 3'd4; in_a_size = 3'd2; in_a_source = 8'h33;
         in_a_address = 31'h3004; in_a_mask = 8'hF0; in_a_valid = 1;
         out_a_ready = 0;
         @(negedge clock);
         check("small_bp_rdy", in_a_ready, 0);
         @(posedge clock);
         #1;
         out_a_ready = 1;
         exp_a.push_back('{31'h3004, {8'h33, 3'd2, 3'd0}, 3'd2, 8'hF0, 1'b1});
         send_a(0);
      end
      @(posedge clock);
      #1;
      check("a_left", exp_a.size(), 0);
      check("d_left", exp_d.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
